cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_responder.sv | 144 ++++++++++++++
 tb/tb_cpu_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multicycle CPU: word array, memory-mapped io_out, sticky err.
// Optional read wait states are enabled by defining MEM_WAIT_EN.
module cpu_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 255,
    parameter int IO_ADDR     = 255,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataW,
    output logic [DATA_W-1:0] dataR,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    output logic [DATA_W-1:0] io_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef MEM_WAIT_EN
        WAIT = 2'd1,
`endif
        RESP = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              rd_req, wr_req, fire, err_set;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;

    function automatic logic in_array(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return int'(a) == IO_ADDR;
    endfunction

`ifdef MEM_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] addr_p0;

    assign busy    = (state == WAIT);
    assign rd_addr = busy ? addr_p0 : addr;
`else
    assign busy    = 1'b0;
    assign rd_addr = addr;
`endif

    // A simultaneous read+write keeps only the write; everything is dropped while busy.
    assign rd_req  = MemRead & ~MemWrite & ~busy;
    assign wr_req  = MemWrite & ~busy;
    assign err_set = (busy & (MemRead | MemWrite))
                   | (~busy & MemRead & MemWrite)
                   | ((rd_req | wr_req) & ~in_array(addr) & ~is_io(addr));

    always_comb begin
        rd_word = '0;
        if (in_array(rd_addr))
            rd_word = mem[rd_addr];
        else if (is_io(rd_addr))
            rd_word = io_out;
    end

    always_comb begin
        state_n = state;
        fire    = 1'b0;
`ifdef MEM_WAIT_EN
        cnt_n   = cnt;
        if (state == WAIT) begin
            if (cnt == '0) begin
                state_n = RESP;
                fire    = 1'b1;
            end else begin
                cnt_n = cnt - 1'b1;
            end
        end else begin
            state_n = IDLE;
            if (rd_req) begin
                if (WAIT_CYCLES == 0) begin
                    state_n = RESP;
                    fire    = 1'b1;
                end else begin
                    state_n = WAIT;
                    cnt_n   = CNT_W'(WAIT_CYCLES - 1);
                end
            end
        end
`else
        state_n = IDLE;
        if (rd_req) begin
            state_n = RESP;
            fire    = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            dataR    <= '0;
            err      <= 1'b0;
            io_out   <= '0;
        end else begin
            state    <= state_n;
            rd_valid <= fire;
            if (fire)
                dataR <= rd_word;
            if (err_set)
                err <= 1'b1;
            if (wr_req && is_io(addr))
                io_out <= dataW;
        end
    end

`ifdef MEM_WAIT_EN
    always_ff @(posedge CLK) begin
        if (!reset)
            cnt <= '0;
        else
            cnt <= cnt_n;
    end

    always_ff @(posedge CLK) begin
        if (rd_req)
            addr_p0 <= addr;
    end
`endif

    // Array contents survive reset; writes are simply held off while reset is asserted.
    always_ff @(posedge CLK) begin
        if (reset && wr_req && in_array(addr))
            mem[addr] <= dataW;
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: latency-level reference model compared every cycle plus literal checks.
module tb_cpu_mem_responder;

    localparam int DEPTH   = 255;
    localparam int IO_ADDR = 255;
`ifdef MEM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [15:0] dataW = 16'd0;
    logic [15:0] dataR;
    logic        rd_valid;
    logic        busy;
    logic        err;
    logic [15:0] io_out;

    cpu_mem_responder #(
        .ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH), .IO_ADDR(IO_ADDR), .WAIT_CYCLES(2)
    ) dut (
        .CLK(CLK), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .dataW(dataW), .dataR(dataR), .rd_valid(rd_valid),
        .busy(busy), .err(err), .io_out(io_out)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image plus "read at cycle c answers at c+W" bookkeeping.
    logic [15:0] mem_m [256];
    logic [15:0] e_data = 16'd0;
    logic [15:0] e_io = 16'd0;
    logic [15:0] resp_val = 16'd0;
    logic        e_valid = 1'b0;
    logic        e_err = 1'b0;
    logic        e_busy = 1'b0;
    int          cyc = 0;
    int          resp_due = -1;
    int          busy_left = 0;
    bit          live = 1'b0;

    function automatic logic [15:0] look(input logic [7:0] a);
        if (int'(a) < DEPTH) return mem_m[a];
        if (int'(a) == IO_ADDR) return e_io;
        return 16'd0;
    endfunction

    always @(posedge CLK) begin
        cyc++;
        live = 1'b1;
        if (!reset) begin
            e_valid = 1'b0; e_data = 16'd0; e_io = 16'd0; e_err = 1'b0; e_busy = 1'b0;
            resp_due = -1; busy_left = 0;
        end else begin
            e_valid = 1'b0;
            if (resp_due == cyc) begin
                e_valid  = 1'b1;
                e_data   = resp_val;
                resp_due = -1;
            end
            if (busy_left > 0) begin
                busy_left--;
                if (MemRead || MemWrite) e_err = 1'b1;
            end else if (MemWrite) begin
                if (MemRead) e_err = 1'b1;
                if (int'(addr) < DEPTH) mem_m[addr] = dataW;
                else if (int'(addr) == IO_ADDR) e_io = dataW;
                else e_err = 1'b1;
            end else if (MemRead) begin
                if (int'(addr) >= DEPTH && int'(addr) != IO_ADDR) e_err = 1'b1;
                if (W == 0) begin
                    e_valid = 1'b1;
                    e_data  = look(addr);
                end else begin
                    resp_val  = look(addr);
                    resp_due  = cyc + W;
                    busy_left = W;
                end
            end
            e_busy = (busy_left > 0);
        end
    end

    always @(negedge CLK) begin
        if (live) begin
            check("m_rd_valid", 32'(rd_valid), 32'(e_valid));
            check("m_dataR",    32'(dataR),    32'(e_data));
            check("m_err",      32'(err),      32'(e_err));
            check("m_io_out",   32'(io_out),   32'(e_io));
            check("m_busy",     32'(busy),     32'(e_busy));
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
        MemRead = rd; MemWrite = wr; addr = a; dataW = d;
        @(posedge CLK); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_dataR", 32'(dataR), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_io",    32'(io_out), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);

`ifndef MEM_WAIT_EN
        // Read-after-write, one-cycle latency
        drive(1'b0, 1'b1, 8'd5, 16'hBEEF);
        drive(1'b1, 1'b0, 8'd5, 16'h0);
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_data",  32'(dataR), 32'hBEEF);
        check("t1_err",   32'(err), 32'd0);

        // Back-to-back reads
        drive(1'b0, 1'b1, 8'd1, 16'h0011);
        drive(1'b0, 1'b1, 8'd2, 16'h0022);
        drive(1'b0, 1'b1, 8'd3, 16'h0033);
        drive(1'b0, 1'b1, 8'd9, 16'h0909);
        drive(1'b1, 1'b0, 8'd1, 16'h0);
        check("t2_v1", 32'(rd_valid), 32'd1);
        check("t2_d1", 32'(dataR), 32'h0011);
        drive(1'b1, 1'b0, 8'd2, 16'h0);
        check("t2_v2", 32'(rd_valid), 32'd1);
        check("t2_d2", 32'(dataR), 32'h0022);
        drive(1'b1, 1'b0, 8'd3, 16'h0);
        check("t2_v3", 32'(rd_valid), 32'd1);
        check("t2_d3", 32'(dataR), 32'h0033);
        idle(1);
        check("t2_drop", 32'(rd_valid), 32'd0);
        check("t2_hold", 32'(dataR), 32'h0033);

        // Memory-mapped io_out
        drive(1'b0, 1'b1, 8'd255, 16'h00A5);
        check("t3_io", 32'(io_out), 32'h00A5);
        drive(1'b1, 1'b0, 8'd255, 16'h0);
        check("t3_rdio", 32'(dataR), 32'h00A5);
        drive(1'b1, 1'b0, 8'd5, 16'h0);
        check("t3_arr", 32'(dataR), 32'hBEEF);
        check("t3_err", 32'(err), 32'd0);

        // Read and write together
        drive(1'b1, 1'b1, 8'd7, 16'h1234);
        check("t4_valid", 32'(rd_valid), 32'd0);
        check("t4_err",   32'(err), 32'd1);
        idle(3);
        check("t4_sticky", 32'(err), 32'd1);
        drive(1'b1, 1'b0, 8'd7, 16'h0);
        check("t4_mem", 32'(dataR), 32'h1234);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("t4_clr", 32'(err), 32'd0);

        // Reset drops a pending read
        drive(1'b0, 1'b1, 8'd255, 16'h0055);
        check("t5_io", 32'(io_out), 32'h0055);
        drive(1'b1, 1'b0, 8'd9, 16'h0);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("t5_valid", 32'(rd_valid), 32'd0);
        check("t5_data",  32'(dataR), 32'd0);
        check("t5_io0",   32'(io_out), 32'd0);
        check("t5_busy",  32'(busy), 32'd0);
        idle(3);
        check("t5_quiet", 32'(rd_valid), 32'd0);
        drive(1'b1, 1'b0, 8'd9, 16'h0);
        check("t5_keep", 32'(dataR), 32'h0909);
`else
        // Wait states: busy window, ignored write, delayed response
        drive(1'b0, 1'b1, 8'd5, 16'hBEEF);
        drive(1'b1, 1'b0, 8'd5, 16'h0);
        check("t6_busy1", 32'(busy), 32'd1);
        check("t6_nov1",  32'(rd_valid), 32'd0);
        drive(1'b0, 1'b1, 8'd5, 16'hDEAD);
        check("t6_busy2", 32'(busy), 32'd1);
        check("t6_err",   32'(err), 32'd1);
        idle(1);
        check("t6_busy3", 32'(busy), 32'd0);
        check("t6_valid", 32'(rd_valid), 32'd1);
        check("t6_data",  32'(dataR), 32'hBEEF);
        idle(1);
        check("t6_drop", 32'(rd_valid), 32'd0);
        drive(1'b1, 1'b0, 8'd5, 16'h0);
        idle(2);
        check("t6_v2",  32'(rd_valid), 32'd1);
        check("t6_ign", 32'(dataR), 32'hBEEF);
`endif
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
